timer_req_scheduler: RTL
========================

TIMER_REQ_SCHEDULER -- requirements
Module: timer_req_scheduler

Interface
REQ-001 SHALL have parameter WDOG_SLACK, default 16, extra cycles allowed beyond the requested period before a watchdog error.
REQ-002 SHALL have port clk, input, 1: the single clock for all logic.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 2: per-client level request, held until done or dropped to cancel.
REQ-005 SHALL have ports period0 and period1, input, 32 each: the one-shot timeout length of each client in timer ticks.
REQ-006 SHALL have port grant, output, 2: one-hot; marks the client currently owning the timer.
REQ-007 SHALL have port done, output, 2: one-cycle completion pulse per client.
REQ-008 SHALL have port status, output, 2, valid with done: 00 ok, 01 zero period, 10 cancelled, 11 watchdog.
REQ-009 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port tmr_address, output, 3: interval-timer slave address.
REQ-011 SHALL have ports tmr_chipselect (output, 1), tmr_write_n (output, 1) and tmr_writedata (output, 16): interval-timer slave write controls and data.
REQ-012 SHALL have port tmr_irq, input, 1: interval-timer interrupt.

Function
REQ-013 SHALL drive all tmr_* outputs from registers, and each write SHALL be exactly one cycle with chipselect=1 and write_n=0; the timer has no waitrequest.
REQ-014 SHALL hold chipselect=0, write_n=1, address=0 and writedata=0 outside write states.
REQ-015 SHALL implement these states: INIT_STOP, INIT_CLR, IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STOP, CLR_STS, DONE.
REQ-016 INIT_STOP SHALL write address 1 with data 0x0008 (stop); INIT_CLR SHALL write address 0 with data 0; the FSM SHALL then enter IDLE. Requests SHALL be ignored until IDLE.
REQ-017 In IDLE, when any req bit is high, the FSM SHALL pick a winner by round-robin. On a tie the client not served last SHALL win, and the pointer SHALL favour client 0 after reset.
REQ-018 On winning, the FSM SHALL latch the winner's period, assert grant on the next cycle and hold it until DONE inclusive.
REQ-019 If the latched period is 0, the FSM SHALL go straight to DONE with status 01 and SHALL NOT write to the timer.
REQ-020 The programming sequence SHALL be: WR_PL writes address 2 with period[15:0]; WR_PH writes address 3 with period[31:16]; WR_CTRL writes address 1 with 0x0005 (ITO=1, CONT=0, START=1); the FSM then enters WAIT_IRQ.
REQ-021 The first timer write SHALL occur 1 cycle after the IDLE cycle that samples req.
REQ-022 The watchdog SHALL be a 33-bit counter loaded in WR_CTRL with period+WDOG_SLACK, zero-extended with no overflow, and decremented each cycle in WAIT_IRQ.
REQ-023 In WAIT_IRQ, tmr_irq=1 SHALL lead to CLR_STS with status 00.
REQ-024 In WAIT_IRQ, the granted req=0 SHALL lead to WR_STOP with status 10.
REQ-025 In WAIT_IRQ, the watchdog reaching 0 SHALL lead to WR_STOP with status 11.
REQ-026 Priority on simultaneous events in WAIT_IRQ SHALL be irq > cancel > watchdog.
REQ-027 A req drop during WR_PL, WR_PH or WR_CTRL SHALL be ignored until WAIT_IRQ, so programming is never truncated.
REQ-028 WR_STOP SHALL write address 1 with 0x0008, then go to CLR_STS.
REQ-029 CLR_STS SHALL write address 0 with 0, then go to DONE.
REQ-030 DONE SHALL pulse done[winner] for 1 cycle with status, update the round-robin pointer, then go to IDLE. Grant SHALL be low in IDLE.
REQ-031 The served client's req SHALL NOT be re-sampled in the first IDLE cycle after DONE, so a client has 1 cycle to drop req.
REQ-032 A req rising for the non-granted client while busy SHALL wait; it SHALL never pre-empt the granted client.

Reset
REQ-033 reset SHALL put the FSM in INIT_STOP, clear grant, done, status and the watchdog, set the pointer to favour client 0, and drive tmr_* to the idle values.
REQ-034 reset asserted mid-operation SHALL abandon the operation with no done pulse; the INIT writes quiesce the timer after reset.
REQ-035 busy SHALL be 1 during INIT_STOP and INIT_CLR.

Verification
REQ-036 After reset release, the bench SHALL see writes (addr1, 0x0008) then (addr0, 0x0000) on consecutive cycles, then busy=0.
REQ-037 With req=01 and period0=0x0001_0002, the bench SHALL see writes (2,0x0002), (3,0x0001), (1,0x0005) on consecutive cycles. tmr_irq pulsed after 65540 cycles -> write (0,0), then done[0]=1 with status 00.
REQ-038 With req=11 from idle, the bench SHALL see client 0 served first, then client 1 with no further stimulus; a third request from client 0 -> client 1 is not starved.
REQ-039 With period1=0, the bench SHALL see done[1] with status 01 two cycles after sampling and zero timer writes.
REQ-040 Dropping req[0] in WAIT_IRQ -> write (1,0x0008), write (0,0), done[0] with status 10.
REQ-041 With period=5, WDOG_SLACK=16 and irq held low, the bench SHALL see the stop write 21 cycles after WR_CTRL and status 11. irq and cancel in the same cycle -> status 00.

Source files
------------

// File: rtl/timer_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_req_scheduler
//  Description : Round-robin scheduler granting two clients exclusive use of
//                an interval-timer slave. Programs a one-shot timeout for the
//                winner, waits for the timer interrupt (guarded by a
//                watchdog), quiesces the timer and reports a completion status.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_req_scheduler #(
    parameter int unsigned WDOG_SLACK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] period0,
    input  logic [31:0] period1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  status,
    output logic        busy,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq
);

    typedef enum logic [3:0] {
        INIT_STOP = 4'd0,
        INIT_CLR  = 4'd1,
        IDLE      = 4'd2,
        WR_PL     = 4'd3,
        WR_PH     = 4'd4,
        WR_CTRL   = 4'd5,
        WAIT_IRQ  = 4'd6,
        WR_STOP   = 4'd7,
        CLR_STS   = 4'd8,
        DONE      = 4'd9
    } state_t;

    // Interval-timer register map
    localparam logic [2:0]  C_ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  C_ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  C_ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  C_ADDR_PERIODH = 3'd3;

    // Control register values: STOP bit alone, or ITO|START for a one-shot
    localparam logic [15:0] C_CTRL_STOP    = 16'h0008;
    localparam logic [15:0] C_CTRL_START   = 16'h0005;

    // Completion status codes
    localparam logic [1:0]  C_ST_OK        = 2'b00;
    localparam logic [1:0]  C_ST_ZERO      = 2'b01;
    localparam logic [1:0]  C_ST_CANCEL    = 2'b10;
    localparam logic [1:0]  C_ST_WDOG      = 2'b11;

    state_t       state_q;
    logic [1:0]   grant_q;
    logic [1:0]   done_q;
    logic [1:0]   status_q;
    logic [1:0]   result_q;     // outcome of the current service, reported in DONE
    logic         ptr_q;        // client favoured when both request
    logic         winner_q;     // client being served (or last served)
    logic         skip_q;       // mask last-served client for one IDLE cycle
    logic [31:0]  period_q;
    logic [32:0]  wdog_q;

    logic [2:0]   addr_q;
    logic         cs_q;
    logic         wn_q;
    logic [15:0]  wdata_q;

    logic [1:0]   req_mask_d;
    logic [1:0]   req_eff_d;
    logic         winner_d;
    logic [31:0]  period_d;
    logic [32:0]  wdog_load_d;
    logic [32:0]  wdog_dec_d;
    logic         cancel_d;

    // Arbitration, period selection and watchdog arithmetic
    always_comb begin
        req_mask_d = 2'b11;
        if (skip_q) begin
            req_mask_d[winner_q] = 1'b0;
        end
        req_eff_d   = req & req_mask_d;
        winner_d    = (req_eff_d == 2'b11) ? ptr_q : req_eff_d[1];
        period_d    = winner_d ? period1 : period0;
        wdog_load_d = {1'b0, period_q} + 33'(WDOG_SLACK);
        wdog_dec_d  = wdog_q - 33'd1;
        cancel_d    = ~req[winner_q];
    end

    // Main controller. Timer writes are loaded on entry to a write state so
    // the bus cycle lines up with the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT_STOP;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            status_q <= 2'b00;
            result_q <= C_ST_OK;
            ptr_q    <= 1'b0;
            winner_q <= 1'b0;
            skip_q   <= 1'b0;
            period_q <= 32'd0;
            wdog_q   <= 33'd0;
            addr_q   <= 3'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= 16'd0;
        end else begin
            // Idle bus and no completion unless a state below says otherwise
            done_q   <= 2'b00;
            status_q <= 2'b00;
            addr_q   <= 3'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= 16'd0;

            case (state_q)
                // Reset leaves the bus idle, so the first cycle here only
                // launches the stop write; the second hands over to the clear.
                INIT_STOP: begin
                    if (!cs_q) begin
                        addr_q  <= C_ADDR_CONTROL;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        wdata_q <= C_CTRL_STOP;
                    end else begin
                        addr_q  <= C_ADDR_STATUS;
                        cs_q    <= 1'b1;
                        wn_q    <= 1'b0;
                        wdata_q <= 16'd0;
                        state_q <= INIT_CLR;
                    end
                end

                INIT_CLR: begin
                    state_q <= IDLE;
                end

                IDLE: begin
                    skip_q <= 1'b0;
                    if (req_eff_d != 2'b00) begin
                        winner_q <= winner_d;
                        period_q <= period_d;
                        grant_q  <= winner_d ? 2'b10 : 2'b01;
                        if (period_d == 32'd0) begin
                            // Nothing to time: complete without touching the timer
                            result_q <= C_ST_ZERO;
                            state_q  <= DONE;
                        end else begin
                            addr_q  <= C_ADDR_PERIODL;
                            cs_q    <= 1'b1;
                            wn_q    <= 1'b0;
                            wdata_q <= period_d[15:0];
                            state_q <= WR_PL;
                        end
                    end
                end

                WR_PL: begin
                    addr_q  <= C_ADDR_PERIODH;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    wdata_q <= period_q[31:16];
                    state_q <= WR_PH;
                end

                WR_PH: begin
                    addr_q  <= C_ADDR_CONTROL;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    wdata_q <= C_CTRL_START;
                    state_q <= WR_CTRL;
                end

                WR_CTRL: begin
                    wdog_q  <= wdog_load_d;
                    state_q <= WAIT_IRQ;
                end

                // Requests are only inspected here, so programming always
                // completes; irq beats cancel beats watchdog.
                WAIT_IRQ: begin
                    wdog_q <= wdog_dec_d;
                    if (tmr_irq) begin
                        result_q <= C_ST_OK;
                        addr_q   <= C_ADDR_STATUS;
                        cs_q     <= 1'b1;
                        wn_q     <= 1'b0;
                        wdata_q  <= 16'd0;
                        state_q  <= CLR_STS;
                    end else if (cancel_d) begin
                        result_q <= C_ST_CANCEL;
                        addr_q   <= C_ADDR_CONTROL;
                        cs_q     <= 1'b1;
                        wn_q     <= 1'b0;
                        wdata_q  <= C_CTRL_STOP;
                        state_q  <= WR_STOP;
                    end else if (wdog_dec_d == 33'd0) begin
                        result_q <= C_ST_WDOG;
                        addr_q   <= C_ADDR_CONTROL;
                        cs_q     <= 1'b1;
                        wn_q     <= 1'b0;
                        wdata_q  <= C_CTRL_STOP;
                        state_q  <= WR_STOP;
                    end
                end

                WR_STOP: begin
                    addr_q  <= C_ADDR_STATUS;
                    cs_q    <= 1'b1;
                    wn_q    <= 1'b0;
                    wdata_q <= 16'd0;
                    state_q <= CLR_STS;
                end

                CLR_STS: begin
                    state_q <= DONE;
                end

                // Report completion, hand priority to the other client and
                // give the served client one IDLE cycle to drop its request.
                DONE: begin
                    done_q   <= winner_q ? 2'b10 : 2'b01;
                    status_q <= result_q;
                    grant_q  <= 2'b00;
                    ptr_q    <= ~winner_q;
                    skip_q   <= 1'b1;
                    state_q  <= IDLE;
                end

                default: begin
                    state_q <= INIT_STOP;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign status         = status_q;
    assign busy           = (state_q != IDLE);
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;

endmodule
`default_nettype wire
